// File: rtl/game_pkg.sv
// Shared phase encoding and default tick constants for the Snake screen sequencer.
package game_pkg;
  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSED    = 3'd3,
    GAMEOVER  = 3'd4
  } state_t;

  localparam int DEF_COUNTDOWN_TICKS     = 3;
  localparam int DEF_GAMEOVER_HOLD_TICKS = 60;
endpackage

// File: rtl/game_phase_ctrl_rise_detect.sv
// Registered rising-edge detector; preset to 1 so a level held through reset gives no edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b1;
    else     r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/game_phase_ctrl.sv
// Title / countdown / play / pause / game-over sequencer driving overlay selects and snake-core enables.
module game_phase_ctrl
  import game_pkg::*;
#(
  parameter int CNT_W               = 8,
  parameter int COUNTDOWN_TICKS     = DEF_COUNTDOWN_TICKS,
  parameter int GAMEOVER_HOLD_TICKS = DEF_GAMEOVER_HOLD_TICKS,
  parameter int SKIP_TITLE          = 0,
  parameter int GAME_CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  is_dead,
  output logic                  show_title,
  output logic                  show_game_over,
  output logic                  show_paused,
  output logic                  game_run,
  output logic                  new_game,
  output logic [CNT_W-1:0]      countdown,
  output logic [GAME_CNT_W-1:0] games_played
);
  localparam logic [CNT_W-1:0] LP_CD   = CNT_W'(COUNTDOWN_TICKS);
  localparam logic [CNT_W-1:0] LP_HOLD = CNT_W'(GAMEOVER_HOLD_TICKS);
  localparam state_t           LP_GO   = (COUNTDOWN_TICKS == 0) ? PLAY : COUNTDOWN;

  state_t                r_state, w_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt, r_hold, w_hold;
  logic [GAME_CNT_W-1:0] r_games, w_games;
  logic                  w_ng, w_start_rise, w_pause_rise;
  logic                  r_title, r_over, r_paused, r_run, r_ng;

  rise_detect u_start_rd (.clk(clk), .rst(rst), .i_d(start), .o_rise(w_start_rise));
  rise_detect u_pause_rd (.clk(clk), .rst(rst), .i_d(pause), .o_rise(w_pause_rise));

  always_comb begin
    w_nxt   = r_state;
    w_cnt   = r_cnt;
    w_hold  = r_hold;
    w_games = r_games;
    w_ng    = 1'b0;
    case (r_state)
      TITLE: if (w_start_rise) begin
        w_nxt = LP_GO;
        w_cnt = LP_CD;
        w_ng  = 1'b1;
      end
      COUNTDOWN: if (tick) begin
        w_cnt = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_nxt = PLAY;
          w_cnt = '0;
        end
      end
      PLAY: if (is_dead) begin
        w_nxt  = GAMEOVER;
        w_hold = LP_HOLD;
        if (r_games != '1) w_games = r_games + 1'b1;
      end else if (w_pause_rise) begin
        w_nxt = PAUSED;
      end
      PAUSED: if (w_pause_rise) w_nxt = PLAY;
      GAMEOVER: begin
        // A press during the hold window is simply dropped; only a fresh edge after hold==0 counts.
        if (w_start_rise && r_hold == '0) begin
          if (SKIP_TITLE != 0) begin
            w_nxt = LP_GO;
            w_cnt = LP_CD;
            w_ng  = 1'b1;
          end else begin
            w_nxt = TITLE;
          end
        end else if (tick && r_hold != '0) begin
          w_hold = r_hold - 1'b1;
        end
      end
      default: begin
        w_nxt = TITLE;
        w_cnt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= TITLE;
      r_cnt    <= '0;
      r_hold   <= '0;
      r_games  <= '0;
      r_ng     <= 1'b0;
      r_title  <= 1'b1;
      r_over   <= 1'b0;
      r_paused <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt;
      r_hold   <= w_hold;
      r_games  <= w_games;
      r_ng     <= w_ng;
      r_title  <= (w_nxt == TITLE);
      r_over   <= (w_nxt == GAMEOVER);
      r_paused <= (w_nxt == PAUSED);
      r_run    <= (w_nxt == PLAY);
    end
  end

  assign show_title     = r_title;
  assign show_game_over = r_over;
  assign show_paused    = r_paused;
  assign game_run       = r_run;
  assign new_game       = r_ng;
  assign countdown      = r_cnt;
  assign games_played   = r_games;
endmodule

// File: doc/game_phase_ctrl.md
Name: game_phase_ctrl

Overview:
Parametrised top-level screen/phase sequencer for the Snake game. It extends the title/game-over splash controller with a countdown before play, a pause screen, a minimum game-over hold time, a skip-title mode and a games-played counter. It sits between the button debouncers and the VGA overlay / snake core. It drives the screen-select flags, the snake-core run enable and a one-cycle new-game clear pulse.

Parameters:
CNT_W, 8, width of the tick counters (countdown and hold).
COUNTDOWN_TICKS, 3, frame ticks spent in COUNTDOWN; 0 means skip straight to PLAY.
GAMEOVER_HOLD_TICKS, 60, frame ticks during which start is ignored in GAMEOVER.
SKIP_TITLE, 0, 1 means restart from GAMEOVER goes to COUNTDOWN instead of TITLE.
GAME_CNT_W, 8, width of the games-played counter.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tick  in  1  one-cycle frame strobe; all tick counters advance only on it
start  in  1  debounced start button, active-high level
pause  in  1  debounced pause button, active-high level
is_dead  in  1  snake core collision flag, level
show_title  out  1  title overlay select
show_game_over  out  1  game-over overlay select
show_paused  out  1  pause overlay select
game_run  out  1  snake core advance enable
new_game  out  1  one-cycle pulse to clear snake/score
countdown  out  CNT_W  remaining countdown ticks; 0 outside COUNTDOWN
games_played  out  GAME_CNT_W  number of completed games, saturating

Behaviour:
- Reset (async, rst=1): state=TITLE, all counters 0, new_game=0, start/pause edge registers preset to 1. The preset means a button held through reset produces no edge.
- start_rise = start & ~start_q, and pause_rise likewise; the _q registers sample every clk.
- State and output flags are registered; flags are a pure decode of the current state:
  - show_title is 1 only in TITLE.
  - show_game_over is 1 only in GAMEOVER.
  - show_paused is 1 only in PAUSED.
  - game_run is 1 only in PLAY.
- TITLE: on start_rise, go to COUNTDOWN, load cnt=COUNTDOWN_TICKS and assert new_game on the next cycle. If COUNTDOWN_TICKS==0, go directly to PLAY, with new_game still pulsed.
- COUNTDOWN: on tick, cnt decrements. A tick while cnt==1 goes to PLAY. countdown output = cnt. pause and is_dead are ignored.
- PLAY:
  - is_dead=1 goes to GAMEOVER. is_dead has priority over a simultaneous pause_rise.
  - Otherwise pause_rise goes to PAUSED.
- PAUSED: pause_rise returns to PLAY. start and is_dead are ignored. cnt is unchanged.
- GAMEOVER entry: load hold=GAMEOVER_HOLD_TICKS, and games_played increments by 1, saturating at all-ones.
- GAMEOVER: on tick with hold!=0, hold decrements. start_rise with hold==0 goes to TITLE, or to COUNTDOWN with the new_game pulse if SKIP_TITLE=1. start_rise while hold!=0 is discarded; it does not re-arm later.
- new_game is exactly one clk wide, registered, and coincides with the first cycle of the entered state.
- Simultaneous tick and transition: the transition wins and the counter loads rather than decrements.
- Reset mid-game returns to TITLE within the same cycle (async). games_played clears.
- Unused state encodings decode to TITLE on the next clk.

Decomposition:
- Shared package game_pkg holds:
  - the state encoding constants TITLE=3'd0, COUNTDOWN=3'd1, PLAY=3'd2, PAUSED=3'd3, GAMEOVER=3'd4;
  - the default tick constants.
- One natural sub-module: rise_detect (1-bit registered edge detector with reset preset to 1). It is instantiated for start and pause.

Test Plan:
- Reset with start held high, release, press once -> no transition on release; on press, COUNTDOWN entered, new_game high 1 cycle, countdown=3.
- In COUNTDOWN, 3 ticks -> countdown 3,2,1 then PLAY with game_run=1 on the cycle after the third tick.
- In PLAY, assert pause_rise and is_dead in the same cycle -> GAMEOVER, show_game_over=1, games_played 0->1.
- In PLAY, pause, then pause again -> PAUSED (show_paused=1, game_run=0), then back to PLAY. An is_dead pulse while PAUSED is ignored.
- GAMEOVER_HOLD_TICKS=4: start at tick 2 -> stays in GAMEOVER; start after 4 ticks -> TITLE. With SKIP_TITLE=1, the same start instead enters COUNTDOWN with a new_game pulse.
- GAME_CNT_W=2: play 5 games -> games_played reads 1,2,3,3,3. Asserting rst mid-PLAY -> TITLE immediately with games_played=0.
